// File: rtl/clk_time_set_ctrl.sv
// clk_time_set_ctrl: button-driven hh:mm:ss setting controller (RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN).
// Latency: state/field changes are visible one cycle after the button edge is sampled; load_o pulses for one cycle on exit.
// No backpressure: buttons are sampled every cycle. Optional auto-repeat is enabled by the macro CLK_SET_AUTOREPEAT_EN.
module clk_time_set_ctrl #(
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       mode_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic [4:0] hour_i,
    input  logic [5:0] min_i,
    input  logic [5:0] sec_i,
    output logic [4:0] hour_set_o,
    output logic [5:0] min_set_o,
    output logic [5:0] sec_set_o,
    output logic       load_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    state_t     state;
    logic       prev_mode, prev_inc, prev_dec;
    logic       mode_edge, inc_edge, dec_edge;
    logic       step_up, step_dn;
    logic [4:0] hour_cap;

    assign mode_edge = mode_i & ~prev_mode;
    assign inc_edge  = inc_i & ~prev_inc;
    assign dec_edge  = dec_i & ~prev_dec;
    assign state_o   = state;

    // Live hour outside 1..12 is not a legal 12-hour value; start editing from 12.
    assign hour_cap = (hour_i == 5'd0 || hour_i > 5'd12) ? 5'd12 : hour_i;

`ifdef CLK_SET_AUTOREPEAT_EN
    localparam int CW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [CW-1:0] FIRST_FIRE = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] NEXT_FIRE  = CW'(REPEAT_DELAY + REPEAT_PERIOD);

    logic [CW-1:0] rpt_cnt, rpt_nxt;
    logic          held_one, rpt_start, rpt_run, rpt_fire;

    // Counter value = cycles held since the initial edge; only one of inc/dec may be held.
    assign held_one  = inc_i ^ dec_i;
    assign rpt_start = held_one & (inc_edge | dec_edge);
    assign rpt_run   = (state != RUN) && held_one && !mode_edge && (rpt_cnt != '0 || rpt_start);
    assign rpt_nxt   = rpt_cnt + 1'b1;
    assign rpt_fire  = rpt_run && !rpt_start && (rpt_nxt == FIRST_FIRE || rpt_nxt == NEXT_FIRE);

    // Hold-time counter; wraps back to the first-fire point so it never exceeds DELAY+PERIOD.
    always_ff @(posedge clk_i) begin
        if (reset_i || !rpt_run) begin
            rpt_cnt <= '0;
        end else if (rpt_start) begin
            rpt_cnt <= CW'(1);
        end else if (rpt_nxt == NEXT_FIRE) begin
            rpt_cnt <= FIRST_FIRE;
        end else begin
            rpt_cnt <= rpt_nxt;
        end
    end

    assign step_up = (inc_edge & ~dec_edge) | (rpt_fire & inc_i);
    assign step_dn = (dec_edge & ~inc_edge) | (rpt_fire & dec_i);
`else
    assign step_up = inc_edge & ~dec_edge;
    assign step_dn = dec_edge & ~inc_edge;
`endif

    function automatic logic [4:0] step_hour(input logic [4:0] v, input logic up);
        if (up) return (v >= 5'd12) ? 5'd1 : v + 5'd1;
        else    return (v <= 5'd1) ? 5'd12 : v - 5'd1;
    endfunction

    function automatic logic [5:0] step_60(input logic [5:0] v, input logic up);
        if (up) return (v >= 6'd59) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    // Mode sequencing, field stepping and the one-cycle load strobe; mode edges take priority over steps.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= RUN;
            hour_set_o <= 5'd12;
            min_set_o  <= 6'd0;
            sec_set_o  <= 6'd0;
            load_o     <= 1'b0;
            prev_mode  <= 1'b1;
            prev_inc   <= 1'b1;
            prev_dec   <= 1'b1;
        end else begin
            prev_mode <= mode_i;
            prev_inc  <= inc_i;
            prev_dec  <= dec_i;
            load_o    <= 1'b0;
            case (state)
                RUN: begin
                    if (mode_edge) begin
                        hour_set_o <= hour_cap;
                        min_set_o  <= min_i;
                        sec_set_o  <= sec_i;
                        state      <= SET_HOUR;
                    end
                end
                SET_HOUR: begin
                    if (mode_edge)                state      <= SET_MIN;
                    else if (step_up || step_dn) hour_set_o <= step_hour(hour_set_o, step_up);
                end
                SET_MIN: begin
                    if (mode_edge)                state     <= SET_SEC;
                    else if (step_up || step_dn) min_set_o <= step_60(min_set_o, step_up);
                end
                SET_SEC: begin
                    if (mode_edge) begin
                        state  <= RUN;
                        load_o <= 1'b1;
                    end else if (step_up || step_dn) begin
                        sec_set_o <= step_60(sec_set_o, step_up);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_time_set_ctrl.sv
// Bench for clk_time_set_ctrl: directed vector table, hand sequences, then random stimulus vs a behavioural model.
// Outputs are sampled 1 time unit after each rising edge; inputs change at that same point.
// Define CLK_SET_AUTOREPEAT_EN to also exercise auto-repeat with a short delay/period.
module tb_clk_time_set_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       mode_i = 1'b1, inc_i = 1'b0, dec_i = 1'b0;
    logic [4:0] hour_i = '0;
    logic [5:0] min_i = '0, sec_i = '0;
    logic [4:0] hour_set_o;
    logic [5:0] min_set_o, sec_set_o;
    logic       load_o;
    logic [1:0] state_o;

    localparam int RD = 10;
    localparam int RP = 4;

    always #5 clk_i = ~clk_i;

    clk_time_set_ctrl #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .mode_i(mode_i), .inc_i(inc_i), .dec_i(dec_i),
        .hour_i(hour_i), .min_i(min_i), .sec_i(sec_i),
        .hour_set_o(hour_set_o), .min_set_o(min_set_o), .sec_set_o(sec_set_o),
        .load_o(load_o), .state_o(state_o)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model: mode index 0..3, fields as plain integers with modulo wrap.
    int m_st = 0, m_h = 12, m_m = 0, m_s = 0, m_ld = 0;
    bit pm = 1, pi = 1, pd = 1;
`ifdef CLK_SET_AUTOREPEAT_EN
    int hk = -1;   // cycles since the initial edge of the held button, -1 when idle
`endif

    function automatic logic [19:0] pack(int st, int h, int m, int s, int ld);
        return {st[1:0], h[4:0], m[5:0], s[5:0], ld[0]};
    endfunction

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got st/h/m/s/ld=%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d", name,
                     act[19:18], act[17:13], act[12:7], act[6:1], act[0],
                     exp[19:18], exp[17:13], exp[12:7], exp[6:1], exp[0]);
        end
    endtask

    task automatic model_step(input bit r, input bit m, input bit i, input bit d, input int h, input int mi, input int s);
        bit me, ie, de, up, dn;
        if (r) begin
            m_st = 0; m_h = 12; m_m = 0; m_s = 0; m_ld = 0; pm = 1; pi = 1; pd = 1;
`ifdef CLK_SET_AUTOREPEAT_EN
            hk = -1;
`endif
            return;
        end
        me = m & ~pm; ie = i & ~pi; de = d & ~pd;
        pm = m; pi = i; pd = d;
        m_ld = 0;
        up = ie & ~de;
        dn = de & ~ie;
`ifdef CLK_SET_AUTOREPEAT_EN
        if (m_st == 0 || me || (i == d)) hk = -1;
        else if (ie || de) hk = 0;
        else if (hk >= 0) hk++;
        if (hk >= RD - 1 && ((hk - (RD - 1)) % RP) == 0) begin
            up = up | i;
            dn = dn | d;
        end
`endif
        if (m_st == 0) begin
            if (me) begin
                m_h = (h == 0 || h > 12) ? 12 : h;
                m_m = mi; m_s = s; m_st = 1;
            end
        end else if (me) begin
            if (m_st == 3) m_ld = 1;
            m_st = (m_st + 1) % 4;
        end else if (up || dn) begin
            case (m_st)
                1: m_h = up ? (m_h % 12) + 1 : ((m_h + 10) % 12) + 1;
                2: m_m = up ? (m_m + 1) % 60 : (m_m + 59) % 60;
                default: m_s = up ? (m_s + 1) % 60 : (m_s + 59) % 60;
            endcase
        end
    endtask

    // One clock: drive inputs, advance the model, sample the DUT and compare against the model.
    task automatic tick(input bit r, input bit m, input bit i, input bit d, input int h, input int mi, input int s,
                        input string name);
        reset_i = r; mode_i = m; inc_i = i; dec_i = d;
        hour_i = h[4:0]; min_i = mi[5:0]; sec_i = s[5:0];
        @(posedge clk_i);
        model_step(r, m, i, d, h, mi, s);
        #1;
        chk({name, "_model"}, {state_o, hour_set_o, min_set_o, sec_set_o, load_o}, pack(m_st, m_h, m_m, m_s, m_ld));
    endtask

    typedef struct {
        bit rst, mode, inc, dec;
        int h, m, s;
        int st, eh, em, es, ld;
    } vec_t;

    function automatic vec_t mk(bit r, bit mo, bit i, bit d, int h, int m, int s,
                                int st, int eh, int em, int es, int ld);
        vec_t v;
        v.rst = r; v.mode = mo; v.inc = i; v.dec = d; v.h = h; v.m = m; v.s = s;
        v.st = st; v.eh = eh; v.em = em; v.es = es; v.ld = ld;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        //                rst mo in de  h  m  s   | st  h  m  s ld
        tbl.push_back(mk(1, 1, 0, 0, 11, 59, 30,   0, 12,  0,  0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 11, 59, 30,   0, 12,  0,  0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 11, 59, 30,   0, 12,  0,  0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 11, 59, 30,   0, 12,  0,  0, 0));  // mode held through release: no edge
        tbl.push_back(mk(0, 0, 0, 0, 11, 59, 30,   0, 12,  0,  0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 11, 59, 30,   1, 11, 59, 30, 0));  // capture
        tbl.push_back(mk(0, 0, 1, 0, 11, 59, 30,   1, 12, 59, 30, 0));
        tbl.push_back(mk(0, 0, 0, 0, 11, 59, 30,   1, 12, 59, 30, 0));
        tbl.push_back(mk(0, 0, 1, 0, 11, 59, 30,   1,  1, 59, 30, 0));  // 12 -> 1
        tbl.push_back(mk(0, 0, 0, 1, 11, 59, 30,   1, 12, 59, 30, 0));  // 1 -> 12
        tbl.push_back(mk(0, 1, 0, 0, 11, 59, 30,   2, 12, 59, 30, 0));
        tbl.push_back(mk(0, 0, 1, 0, 11, 59, 30,   2, 12,  0, 30, 0));  // 59 -> 0
        tbl.push_back(mk(0, 0, 0, 1, 11, 59, 30,   2, 12, 59, 30, 0));  // 0 -> 59
        tbl.push_back(mk(0, 1, 0, 0, 11, 59, 30,   3, 12, 59, 30, 0));
        tbl.push_back(mk(0, 0, 0, 1, 11, 59, 30,   3, 12, 59, 29, 0));
        tbl.push_back(mk(0, 0, 0, 0, 11, 59, 30,   3, 12, 59, 29, 0));
        tbl.push_back(mk(0, 0, 0, 1, 11, 59, 30,   3, 12, 59, 28, 0));
        tbl.push_back(mk(0, 0, 0, 0, 11, 59, 30,   3, 12, 59, 28, 0));
        tbl.push_back(mk(0, 0, 0, 1, 11, 59, 30,   3, 12, 59, 27, 0));
        tbl.push_back(mk(0, 1, 0, 0, 11, 59, 30,   0, 12, 59, 27, 1));  // load strobe
        tbl.push_back(mk(0, 0, 0, 0, 11, 59, 30,   0, 12, 59, 27, 0));  // strobe is one cycle
        tbl.push_back(mk(0, 0, 1, 0, 11, 59, 30,   0, 12, 59, 27, 0));  // inc ignored in RUN
        tbl.push_back(mk(0, 1, 1, 0,  5, 10, 20,   1,  5, 10, 20, 0));
        tbl.push_back(mk(0, 0, 0, 0,  5, 10, 20,   1,  5, 10, 20, 0));
        tbl.push_back(mk(0, 1, 1, 0,  5, 10, 20,   2,  5, 10, 20, 0));  // mode+inc: step dropped
        tbl.push_back(mk(0, 0, 0, 0,  5, 10, 20,   2,  5, 10, 20, 0));
        tbl.push_back(mk(0, 0, 1, 1,  5, 10, 20,   2,  5, 10, 20, 0));  // inc+dec: ignored
        tbl.push_back(mk(0, 0, 0, 0,  5, 10, 20,   2,  5, 10, 20, 0));
        tbl.push_back(mk(0, 0, 1, 0,  5, 10, 20,   2,  5, 11, 20, 0));
        tbl.push_back(mk(0, 0, 0, 0,  5, 10, 20,   2,  5, 11, 20, 0));
        tbl.push_back(mk(0, 1, 0, 0,  5, 10, 20,   3,  5, 11, 20, 0));
        tbl.push_back(mk(0, 0, 0, 0,  5, 10, 20,   3,  5, 11, 20, 0));
        tbl.push_back(mk(0, 1, 0, 0,  5, 10, 20,   0,  5, 11, 20, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0,  7,  8,   0,  5, 11, 20, 0));
        tbl.push_back(mk(0, 1, 0, 0,  0,  7,  8,   1, 12,  7,  8, 0));  // hour 0 clamps to 12
        tbl.push_back(mk(0, 0, 0, 0,  0,  7,  8,   1, 12,  7,  8, 0));
        tbl.push_back(mk(0, 1, 0, 0,  0,  7,  8,   2, 12,  7,  8, 0));
        tbl.push_back(mk(1, 0, 0, 0,  0,  7,  8,   0, 12,  0,  0, 0));  // reset in SET_MIN
        tbl.push_back(mk(0, 0, 0, 0,  0,  7,  8,   0, 12,  0,  0, 0));  // no load afterwards
        tbl.push_back(mk(0, 1, 0, 0, 13, 45,  3,   1, 12, 45,  3, 0));  // hour 13 clamps to 12
        tbl.push_back(mk(0, 0, 0, 0, 13, 45,  3,   1, 12, 45,  3, 0));
        tbl.push_back(mk(0, 0, 0, 1, 13, 45,  3,   1, 11, 45,  3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 13, 45,  3,   1, 11, 45,  3, 0));

        foreach (tbl[k]) begin
            tick(tbl[k].rst, tbl[k].mode, tbl[k].inc, tbl[k].dec, tbl[k].h, tbl[k].m, tbl[k].s,
                 $sformatf("vec%0d", k));
            chk($sformatf("vec%0d", k), {state_o, hour_set_o, min_set_o, sec_set_o, load_o},
                pack(tbl[k].st, tbl[k].eh, tbl[k].em, tbl[k].es, tbl[k].ld));
        end

`ifdef CLK_SET_AUTOREPEAT_EN
        // Auto-repeat: inc held 22 cycles in SET_MIN from 0 gives edge + first repeat + 3 periodic = 5.
        tick(1, 0, 0, 0, 3, 0, 0, "ar_rst");
        tick(0, 0, 0, 0, 3, 0, 0, "ar_idle");
        tick(0, 1, 0, 0, 3, 0, 0, "ar_hour");
        tick(0, 0, 0, 0, 3, 0, 0, "ar_gap");
        tick(0, 1, 0, 0, 3, 0, 0, "ar_min");
        tick(0, 0, 0, 0, 3, 0, 0, "ar_gap2");
        for (int c = 0; c < 22; c++) tick(0, 0, 1, 0, 3, 0, 0, $sformatf("ar_hold%0d", c));
        chk("ar_min_after_hold", {2'd0, 5'd0, min_set_o, 7'd0}, {2'd0, 5'd0, 6'd5, 7'd0});
        for (int c = 0; c < 8; c++) tick(0, 0, 0, 0, 3, 0, 0, $sformatf("ar_rel%0d", c));
        chk("ar_min_after_release", {2'd0, 5'd0, min_set_o, 7'd0}, {2'd0, 5'd0, 6'd5, 7'd0});
`endif

        // Random stimulus; button levels persist for a few cycles so edges and holds both occur.
        begin
            bit rm = 0, ri = 0, rd = 0;
            for (int n = 0; n < 1500; n++) begin
                if ($urandom_range(0, 3) == 0) rm = ~rm;
                if ($urandom_range(0, 4) == 0) ri = ~ri;
                if ($urandom_range(0, 4) == 0) rd = ~rd;
                tick($urandom_range(0, 199) == 0, rm, ri, rd,
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)),
                     $sformatf("rnd%0d", n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
